ram_burst_writer: RTL



---
 rtl/ram_burst_writer.sv | 117 +++++++++++
 1 files changed

// File: rtl/ram_burst_writer.sv
// Small byte memory filled by a start/length burst-write engine over a valid/ready stream.
// Read port is combinational; out-of-range read addresses return zero.
module ram_burst_writer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [ADDR_W-1:0] rd_address,
    output logic [DATA_W-1:0] rd_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t            state_reg;
    logic [PTR_W-1:0]  ptr_reg;
    logic [ADDR_W-1:0] remaining_reg;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              xfer;
    logic              start_in_range;
    logic              rd_in_range;
    logic [PTR_W-1:0]  rd_idx;

    // in_ready is a registered copy of "state is BURST", so it also gates writes.
    assign xfer           = in_valid && in_ready;
    assign start_in_range = ({1'b0, start_addr} < DEPTH_EXT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            remaining_reg <= '0;
            in_ready      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (!start_in_range) begin
                            err       <= 1'b1;
                            done      <= 1'b1;
                            state_reg <= DONE;
                        end else if (length == '0) begin
                            err       <= 1'b0;
                            done      <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            err           <= 1'b0;
                            ptr_reg       <= start_addr[PTR_W-1:0];
                            remaining_reg <= length;
                            in_ready      <= 1'b1;
                            state_reg     <= BURST;
                        end
                    end
                end
                BURST: begin
                    if (xfer) begin
                        ptr_reg       <= (ptr_reg == LAST_PTR) ? '0 : ptr_reg + 1'b1;
                        remaining_reg <= remaining_reg - 1'b1;
                        if (remaining_reg == ADDR_W'(1)) begin
                            in_ready  <= 1'b0;
                            done      <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    in_ready  <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // One register per word so reset can clear the whole table asynchronously.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_word
        logic [DATA_W-1:0] word_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_reg <= '0;
            end else if (xfer && (ptr_reg == PTR_W'(gi))) begin
                word_reg <= in_data;
            end
        end

        assign mem[gi] = word_reg;
    end

    assign rd_in_range = ({1'b0, rd_address} < DEPTH_EXT);
    assign rd_idx      = rd_address[PTR_W-1:0];
    assign rd_data     = rd_in_range ? mem[rd_idx] : '0;

endmodule
